mips_mem_responder: RTL

MIPS_MEM_RESPONDER -- requirements
Module: mips_mem_responder

---
 rtl/mips_mem_responder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mips_mem_responder.sv
// Wait-state memory responder for a MIPS core: captures a request, waits WAIT_CYCLES, then responds.
// Optional address error checking is enabled by defining MEM_RESP_ERR_CHECK_EN.
`timescale 1ns/1ps

module mips_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_LOG2  = 6
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ready_o,
  output logic        err_o
);

  // state   | meaning
  // ST_IDLE | waiting for req; captures we/addr/wdata
  // ST_WAIT | counting down wait states
  // ST_RESP | one-cycle response, ready high
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH];

  logic                  acc_we;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_err;
  logic                  enter_resp;
  logic                  mem_we;

  assign acc_idx = acc_addr[DEPTH_LOG2+1:2];

`ifdef MEM_RESP_ERR_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:DEPTH_LOG2+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:DEPTH_LOG2+2], acc_addr[1:0]};
  assign acc_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = 1'b0;
    acc_we     = we_q;
    acc_addr   = addr_q;
    acc_wdata  = wdata_q;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d      = we_i;
          addr_d    = addr_i;
          wdata_d   = wdata_i;
          cnt_d     = CNT_LOAD;
          // With zero wait states the response uses the inputs of this very edge
          acc_we    = we_i;
          acc_addr  = addr_i;
          acc_wdata = wdata_i;
          if (WAIT_CYCLES == 0) enter_resp = 1'b1;
          else                  state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) enter_resp = 1'b1;
        else               cnt_d      = cnt_q - 4'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (enter_resp) begin
      state_d = ST_RESP;
      err_d   = acc_err;
      if (acc_we) begin
        mem_we  = !acc_err;
        rdata_d = 32'd0;
      end else begin
        rdata_d = acc_err ? 32'd0 : mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset; writes are blocked while reset is held
  always_ff @(posedge clk_i) begin
    if (rst_n_i && mem_we) mem_q[acc_idx] <= acc_wdata;
  end

  assign ready_o = (state_q == ST_RESP);
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule
